// File: rtl/sar_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sar_pkg
//  Description : Shared state encoding and width helpers for the SAR
//                conversion sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package sar_pkg;

    localparam int c_BIT_WIDTH_DEF     = 10;
    localparam int c_SAMPLE_CYCLES_DEF = 2;

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_SAMPLE  = 2'd1;
    localparam logic [1:0] c_ST_CONVERT = 2'd2;
    localparam logic [1:0] c_ST_DONE    = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = c_ST_IDLE,
        ST_SAMPLE  = c_ST_SAMPLE,
        ST_CONVERT = c_ST_CONVERT,
        ST_DONE    = c_ST_DONE
    } sar_state_t;

    // One sample bit plus one bit per binary-search step.
    function automatic int sar_phase_width(input int bit_width);
        return bit_width + 1;
    endfunction

    // Counter width able to index 0..n-1, never narrower than one bit.
    function automatic int sar_cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sar_bit_reg.sv
`default_nettype none
// ============================================================================
//  Module      : sar_bit_reg
//  Description : Successive-approximation register: sets the trial bit,
//                keeps/clears it on the comparator decision, drives the DAC
//                code and holds the final result.
//  Revision    : 1.0 - initial release
// ============================================================================
module sar_bit_reg
    import sar_pkg::*;
#(
    parameter int BIT_WIDTH = c_BIT_WIDTH_DEF,
    parameter int STEP_W    = sar_cnt_width(c_BIT_WIDTH_DEF)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_init,
    input  logic                 i_decide,
    input  logic [STEP_W-1:0]    i_step,
    input  logic                 i_cmp,
    input  logic                 i_trial_en,
    input  logic [STEP_W-1:0]    i_trial_step,
    input  logic                 i_result_ld,
    output logic [BIT_WIDTH-1:0] o_dac_code,
    output logic [BIT_WIDTH-1:0] o_data
);

    logic [BIT_WIDTH-1:0] r_kept_q, w_kept_d;
    logic [BIT_WIDTH-1:0] r_dac_q,  w_dac_d;
    logic [BIT_WIDTH-1:0] r_data_q, w_data_d;

    always_comb begin
        w_kept_d = r_kept_q;
        if (i_init) begin
            w_kept_d = '0;
        end
        // The decision closes the step currently on the DAC.
        if (i_decide) begin
            for (int i = 0; i < BIT_WIDTH; i++) begin
                if (i == BIT_WIDTH - 1 - int'(i_step)) begin
                    w_kept_d[i] = i_cmp;
                end
            end
        end

        w_dac_d = '0;
        if (i_trial_en) begin
            w_dac_d = w_kept_d;
            for (int i = 0; i < BIT_WIDTH; i++) begin
                if (i == BIT_WIDTH - 1 - int'(i_trial_step)) begin
                    w_dac_d[i] = 1'b1;
                end
            end
        end

        w_data_d = i_result_ld ? w_kept_d : r_data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_kept_q <= '0;
            r_dac_q  <= '0;
            r_data_q <= '0;
        end else begin
            r_kept_q <= w_kept_d;
            r_dac_q  <= w_dac_d;
            r_data_q <= w_data_d;
        end
    end

    assign o_dac_code = r_dac_q;
    assign o_data     = r_data_q;

endmodule
`default_nettype wire

// File: rtl/sar_conv_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : sar_conv_ctrl
//  Description : Sequencer for one SAR ADC conversion (sample phase, then
//                BIT_WIDTH binary-search steps, result over valid/ready).
//                Define SAR_CONT_EN to add cont_i for back-to-back conversion.
//  Revision    : 1.0 - initial release
// ============================================================================
module sar_conv_ctrl
    import sar_pkg::*;
#(
    parameter int BIT_WIDTH     = c_BIT_WIDTH_DEF,
    parameter int PHASE_WIDTH   = sar_phase_width(BIT_WIDTH),
    parameter int SAMPLE_CYCLES = c_SAMPLE_CYCLES_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_i,
    input  logic                   cmp_i,
    input  logic                   ready_i,
`ifdef SAR_CONT_EN
    input  logic                   cont_i,
`endif
    output logic                   sample_o,
    output logic [PHASE_WIDTH-1:0] phase_o,
    output logic [BIT_WIDTH-1:0]   dac_code_o,
    output logic [BIT_WIDTH-1:0]   data_o,
    output logic                   valid_o,
    output logic                   busy_o
);

    localparam int c_STEP_W = sar_cnt_width(BIT_WIDTH);
    localparam int c_SAMP_W = sar_cnt_width(SAMPLE_CYCLES);
    localparam logic [c_STEP_W-1:0] c_LAST_STEP = c_STEP_W'(BIT_WIDTH - 1);
    localparam logic [c_SAMP_W-1:0] c_LAST_SAMP = c_SAMP_W'(SAMPLE_CYCLES - 1);

    sar_state_t             r_state_q,  w_state_d;
    logic [c_STEP_W-1:0]    r_step_q,   w_step_d;
    logic [c_SAMP_W-1:0]    r_samp_q,   w_samp_d;
    logic                   r_sample_q, w_sample_d;
    logic [PHASE_WIDTH-1:0] r_phase_q,  w_phase_d;
    logic                   r_valid_q,  w_valid_d;
    logic                   r_busy_q,   w_busy_d;

    logic w_cont;
    logic w_init;
    logic w_decide;
    logic w_trial_en;
    logic w_result_ld;

`ifdef SAR_CONT_EN
    assign w_cont = cont_i;
`else
    assign w_cont = 1'b0;
`endif

    always_comb begin
        w_state_d   = r_state_q;
        w_step_d    = r_step_q;
        w_samp_d    = r_samp_q;
        w_init      = 1'b0;
        w_decide    = 1'b0;
        w_result_ld = 1'b0;

        unique case (r_state_q)
            ST_IDLE: begin
                if (start_i) begin
                    w_state_d = ST_SAMPLE;
                    w_samp_d  = '0;
                end
            end
            ST_SAMPLE: begin
                if (r_samp_q == c_LAST_SAMP) begin
                    w_state_d = ST_CONVERT;
                    w_samp_d  = '0;
                    w_step_d  = '0;
                    w_init    = 1'b1;
                end else begin
                    w_samp_d = r_samp_q + 1'b1;
                end
            end
            ST_CONVERT: begin
                w_decide = 1'b1;
                if (r_step_q == c_LAST_STEP) begin
                    w_state_d   = ST_DONE;
                    w_step_d    = '0;
                    w_result_ld = 1'b1;
                end else begin
                    w_step_d = r_step_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (ready_i) begin
                    w_state_d = w_cont ? ST_SAMPLE : ST_IDLE;
                    w_samp_d  = '0;
                end
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered, so they are derived from the next state.
        w_trial_en = (w_state_d == ST_CONVERT);
        w_sample_d = (w_state_d == ST_SAMPLE);
        w_valid_d  = (w_state_d == ST_DONE);
        w_busy_d   = (w_state_d != ST_IDLE);

        w_phase_d = '0;
        if (w_state_d == ST_SAMPLE) begin
            w_phase_d[0] = 1'b1;
        end else if (w_state_d == ST_CONVERT) begin
            for (int i = 0; i < PHASE_WIDTH; i++) begin
                w_phase_d[i] = (i <= int'(w_step_d) + 1);
            end
        end else if (w_state_d == ST_DONE) begin
            w_phase_d = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q  <= ST_IDLE;
            r_step_q   <= '0;
            r_samp_q   <= '0;
            r_sample_q <= 1'b0;
            r_phase_q  <= '0;
            r_valid_q  <= 1'b0;
            r_busy_q   <= 1'b0;
        end else begin
            r_state_q  <= w_state_d;
            r_step_q   <= w_step_d;
            r_samp_q   <= w_samp_d;
            r_sample_q <= w_sample_d;
            r_phase_q  <= w_phase_d;
            r_valid_q  <= w_valid_d;
            r_busy_q   <= w_busy_d;
        end
    end

    sar_bit_reg #(
        .BIT_WIDTH (BIT_WIDTH),
        .STEP_W    (c_STEP_W)
    ) u_bit_reg (
        .clk          (clk),
        .rst          (rst),
        .i_init       (w_init),
        .i_decide     (w_decide),
        .i_step       (r_step_q),
        .i_cmp        (cmp_i),
        .i_trial_en   (w_trial_en),
        .i_trial_step (w_step_d),
        .i_result_ld  (w_result_ld),
        .o_dac_code   (dac_code_o),
        .o_data       (data_o)
    );

    assign sample_o = r_sample_q;
    assign phase_o  = r_phase_q;
    assign valid_o  = r_valid_q;
    assign busy_o   = r_busy_q;

endmodule
`default_nettype wire
